// File: rtl/dispatch_batch_ctrl_if.sv
// Dispatch batch controller bundle: the rename-side batch handshake, the EU
// is_full snoop inputs, the shared dispatch bus lanes, and the status/perf outputs.
// The master modport is the rename/EU environment; the slave modport is the controller.
interface dispatch_batch_ctrl_if #(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int LOG2_NUM_EXEC_UNITS           = 1,
  parameter int DATA_W                        = 32
);
  localparam int N              = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int NUM_EXEC_UNITS = 2 ** LOG2_NUM_EXEC_UNITS;

  logic                                    batch_req_i;
  logic [N-1:0][DATA_W-1:0]                batch_instr_i;
  logic [N-1:0]                            batch_valid_i;
  logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]   batch_euidx_i;
  logic                                    batch_ack_o;
  logic [NUM_EXEC_UNITS-1:0]               eu_is_full_i;
  logic [N-1:0][DATA_W-1:0]                dispatched_instr_o;
  logic [N-1:0]                            dispatched_instr_valid_o;
  logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]   dispatched_instr_alloc_euidx_o;
  logic                                    busy_o;
  logic                                    stall_err_o;
  logic [31:0]                             perf_batches_o;
  logic [31:0]                             perf_retry_cycles_o;

  modport master (
    output batch_req_i, batch_instr_i, batch_valid_i, batch_euidx_i, eu_is_full_i,
    input  batch_ack_o, dispatched_instr_o, dispatched_instr_valid_o,
           dispatched_instr_alloc_euidx_o, busy_o, stall_err_o,
           perf_batches_o, perf_retry_cycles_o
  );

  modport slave (
    input  batch_req_i, batch_instr_i, batch_valid_i, batch_euidx_i, eu_is_full_i,
    output batch_ack_o, dispatched_instr_o, dispatched_instr_valid_o,
           dispatched_instr_alloc_euidx_o, busy_o, stall_err_o,
           perf_batches_o, perf_retry_cycles_o
  );
endinterface

// File: rtl/dispatch_batch_ctrl.sv
// dispatch_batch_ctrl: latches one rename batch, drives it onto the shared
// dispatch bus, re-drives only lanes whose target EU was full (after a backoff),
// and acks rename once every valid lane has landed.
// Optional feature macro: DISPATCH_PERF_CTR_EN adds the two 32-bit perf counters;
// without it the perf ports read 0 and no counter flops exist.
module dispatch_batch_ctrl #(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int LOG2_NUM_EXEC_UNITS           = 1,
  parameter int DATA_W                        = 32,
  parameter int RETRY_BACKOFF_CYCLES          = 2,
  parameter int MAX_RETRIES                   = 15
) (
  input logic                  clk,
  input logic                  reset_n,
  dispatch_batch_ctrl_if.slave bus
);
  localparam int N = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam logic [7:0] BACKOFF_INIT = 8'(RETRY_BACKOFF_CYCLES - 1);
  localparam logic [3:0] MAX_R        = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_BACKOFF, S_ACK} state_t;

  state_t                                state;
  logic [N-1:0]                          pend_p1;
  logic [N-1:0]                          vld_p1;
  logic [N-1:0][DATA_W-1:0]              instr_p1;
  logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0] euidx_p1;
  logic [3:0]                            retry_ctr;
  logic [3:0]                            retry_inc;
  logic [7:0]                            backoff_ctr;
  logic                                  busy_q;
  logic                                  ack_q;
  logic                                  stall_q;
  logic [N-1:0]                          lane_full;
  logic [N-1:0]                          nxt_pend;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Per-lane rejection: a lane stays pending iff its target EU reports full this cycle.
  always_comb begin
    lane_full = '0;
    for (int l = 0; l < N; l++) begin
      lane_full[l] = bus.eu_is_full_i[euidx_p1[l]];
    end
    nxt_pend  = pend_p1 & lane_full;
    retry_inc = sat_inc4(retry_ctr);
  end

  // ---- stage p1: batch payload latched from rename (data path, no reset) ----
  // Payload capture on an accepted request; masked to 0 at the outputs while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.batch_req_i) begin
      instr_p1 <= bus.batch_instr_i;
      euidx_p1 <= bus.batch_euidx_i;
    end
  end

  // Sequencer FSM with registered bus-valid, ack, busy and stall outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pend_p1     <= '0;
      vld_p1      <= '0;
      retry_ctr   <= '0;
      backoff_ctr <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.batch_req_i) begin
            pend_p1   <= bus.batch_valid_i;
            retry_ctr <= '0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (|bus.batch_valid_i) begin
              state  <= S_DISPATCH;
              vld_p1 <= bus.batch_valid_i;
            end else begin
              state <= S_ACK;
              ack_q <= 1'b1;
            end
          end
        end
        S_DISPATCH: begin
          pend_p1 <= nxt_pend;
          vld_p1  <= '0;
          if (nxt_pend == '0) begin
            state <= S_ACK;
            ack_q <= 1'b1;
          end else begin
            state       <= S_BACKOFF;
            backoff_ctr <= BACKOFF_INIT;
            retry_ctr   <= retry_inc;
            // Sticky alarm only; the batch keeps retrying regardless.
            if (retry_inc >= MAX_R) stall_q <= 1'b1;
          end
        end
        S_BACKOFF: begin
          if (backoff_ctr == '0) begin
            state  <= S_DISPATCH;
            vld_p1 <= pend_p1;
          end else begin
            backoff_ctr <= backoff_ctr - 8'd1;
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dispatched_instr_o             = busy_q ? instr_p1 : '0;
  assign bus.dispatched_instr_alloc_euidx_o = busy_q ? euidx_p1 : '0;
  assign bus.dispatched_instr_valid_o       = vld_p1;
  assign bus.batch_ack_o                    = ack_q;
  assign bus.busy_o                         = busy_q;
  assign bus.stall_err_o                    = stall_q;

`ifdef DISPATCH_PERF_CTR_EN
  logic [31:0] perf_batches_q;
  logic [31:0] perf_retry_q;

  // Wrapping counters: completed batches and cycles spent backing off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_batches_q <= '0;
      perf_retry_q   <= '0;
    end else begin
      if (ack_q)               perf_batches_q <= perf_batches_q + 32'd1;
      if (state == S_BACKOFF)  perf_retry_q   <= perf_retry_q + 32'd1;
    end
  end

  assign bus.perf_batches_o      = perf_batches_q;
  assign bus.perf_retry_cycles_o = perf_retry_q;
`else
  assign bus.perf_batches_o      = '0;
  assign bus.perf_retry_cycles_o = '0;
`endif
endmodule

// File: tb/tb_dispatch_batch_ctrl.sv
// Directed bench for dispatch_batch_ctrl: table of single-batch vectors plus
// hand-written sequences for stall, async reset and perf counters.
module tb_dispatch_batch_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dispatch_batch_ctrl_if #(
    .NUM_PARALLEL_INSTR_DISPATCHES(4), .LOG2_NUM_EXEC_UNITS(1), .DATA_W(32)
  ) bus ();

  dispatch_batch_ctrl #(
    .NUM_PARALLEL_INSTR_DISPATCHES(4), .LOG2_NUM_EXEC_UNITS(1), .DATA_W(32),
    .RETRY_BACKOFF_CYCLES(2), .MAX_RETRIES(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] euidx;    // one EU-index bit per lane
    logic [1:0] full1;    // eu_is_full during the first DISPATCH only
    logic [3:0] exp_v1;   // bus valid at cycle 1
    logic [3:0] exp_v2;   // bus valid at cycle 4 (retry), 0 if none
    int         exp_ack;  // cycle of the ack pulse
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int k);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = 32'hC0DE_0000 + 32'(k*16 + l);
    return r;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},  128'(bus.busy_o), 128'd0);
    chk({nm, "_ack"},   128'(bus.batch_ack_o), 128'd0);
    chk({nm, "_vld"},   128'(bus.dispatched_instr_valid_o), 128'd0);
    chk({nm, "_instr"}, 128'(bus.dispatched_instr_o), 128'd0);
    chk({nm, "_euidx"}, 128'(bus.dispatched_instr_alloc_euidx_o), 128'd0);
    chk({nm, "_stall"}, 128'(bus.stall_err_o), 128'd0);
  endtask

  // Present vector k in IDLE and follow it for 8 cycles.
  task automatic run_vec(input int k);
    vec_t v;
    logic [3:0] ev;
    v = vecs[k];
    bus.batch_req_i   = 1'b1;
    bus.batch_valid_i = v.valid;
    bus.batch_instr_i = pat(k);
    for (int l = 0; l < 4; l++) bus.batch_euidx_i[l] = v.euidx[l];
    bus.eu_is_full_i  = v.full1;
    tick();
    bus.batch_req_i   = 1'b0;
    bus.batch_valid_i = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c >= 2) bus.eu_is_full_i = '0;
      ev = (c == 1) ? v.exp_v1 : ((c == 4) ? v.exp_v2 : 4'b0000);
      chk($sformatf("v%0d_c%0d_vld", k, c),  128'(bus.dispatched_instr_valid_o), 128'(ev));
      chk($sformatf("v%0d_c%0d_ack", k, c),  128'(bus.batch_ack_o), 128'(c == v.exp_ack));
      chk($sformatf("v%0d_c%0d_busy", k, c), 128'(bus.busy_o), 128'(c <= v.exp_ack));
      chk($sformatf("v%0d_c%0d_stall", k, c), 128'(bus.stall_err_o), 128'd0);
      if (c == 1) begin
        chk($sformatf("v%0d_instr", k), 128'(bus.dispatched_instr_o), pat(k));
        chk($sformatf("v%0d_euidx", k), 128'(bus.dispatched_instr_alloc_euidx_o), 128'(v.euidx));
      end
      if (c == 8) chk($sformatf("v%0d_idle_instr", k), 128'(bus.dispatched_instr_o), 128'd0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pb, exp_pr;
    int n;
    // valid, euidx, full1, v1, v2, ack
    vecs[0] = '{4'b1111, 4'b1010, 2'b00, 4'b1111, 4'b0000, 2};
    vecs[1] = '{4'b1111, 4'b1010, 2'b10, 4'b1111, 4'b1010, 5};
    vecs[2] = '{4'b0000, 4'b1010, 2'b00, 4'b0000, 4'b0000, 1};
    vecs[3] = '{4'b0101, 4'b1111, 2'b10, 4'b0101, 4'b0101, 5};
    vecs[4] = '{4'b0011, 4'b0010, 2'b01, 4'b0011, 4'b0001, 5};
    vecs[5] = '{4'b1000, 4'b0000, 2'b00, 4'b1000, 4'b0000, 2};

    bus.batch_req_i   = 1'b0;
    bus.batch_valid_i = '0;
    bus.batch_instr_i = '0;
    bus.batch_euidx_i = '0;
    bus.eu_is_full_i  = '0;

    // Reset state
    tick(); tick();
    chk_all_zero("rst_held");
    reset_n = 1'b1;
    tick();
    chk_all_zero("rst_rel");
    chk("rst_perf_b", 128'(bus.perf_batches_o), 128'd0);
    chk("rst_perf_r", 128'(bus.perf_retry_cycles_o), 128'd0);

    // Table-driven single-batch vectors
    for (int k = 0; k < 6; k++) run_vec(k);

    // Stuck-full EU0: stall raises after 15 retries, clears on next latch
    bus.batch_req_i   = 1'b1;
    bus.batch_valid_i = 4'b0001;
    bus.batch_instr_i = pat(9);
    bus.batch_euidx_i = '0;
    bus.eu_is_full_i  = 2'b01;
    tick();
    bus.batch_req_i   = 1'b0;
    bus.batch_valid_i = '0;
    for (int r = 1; r <= 17; r++) begin
      n = 0;
      while (bus.dispatched_instr_valid_o == '0 && n < 6) begin
        tick();
        n++;
      end
      if (bus.dispatched_instr_valid_o == '0) begin
        chk($sformatf("stall_wait_dispatch_%0d", r), 128'(bus.dispatched_instr_valid_o), 128'b0001);
        break;
      end
      chk($sformatf("stall_r%0d_vld", r), 128'(bus.dispatched_instr_valid_o), 128'b0001);
      chk($sformatf("stall_r%0d_err", r), 128'(bus.stall_err_o), 128'(r >= 16));
      if (r == 17) bus.eu_is_full_i = '0;
      tick();
    end
    chk("stall_ack", 128'(bus.batch_ack_o), 128'd1);
    chk("stall_ack_err", 128'(bus.stall_err_o), 128'd1);
    tick();
    chk("stall_idle_busy", 128'(bus.busy_o), 128'd0);
    chk("stall_idle_err", 128'(bus.stall_err_o), 128'd1);
    bus.batch_req_i   = 1'b1;
    bus.batch_valid_i = 4'b0001;
    tick();
    bus.batch_req_i   = 1'b0;
    bus.batch_valid_i = '0;
    chk("stall_clr_err", 128'(bus.stall_err_o), 128'd0);
    chk("stall_clr_vld", 128'(bus.dispatched_instr_valid_o), 128'b0001);
    tick();
    chk("stall_clr_ack", 128'(bus.batch_ack_o), 128'd1);
    tick();

    // Async reset during BACKOFF
    bus.batch_req_i   = 1'b1;
    bus.batch_valid_i = 4'b1111;
    bus.batch_instr_i = pat(1);
    for (int l = 0; l < 4; l++) bus.batch_euidx_i[l] = 1'(l % 2);
    bus.eu_is_full_i  = 2'b10;
    tick();
    bus.batch_req_i   = 1'b0;
    bus.batch_valid_i = '0;
    tick();
    bus.eu_is_full_i  = '0;
    chk("arst_in_backoff_busy", 128'(bus.busy_o), 128'd1);
    chk("arst_in_backoff_vld", 128'(bus.dispatched_instr_valid_o), 128'd0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("arst_async");
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("arst_after_c%0d_ack", c), 128'(bus.batch_ack_o), 128'd0);
      chk($sformatf("arst_after_c%0d_busy", c), 128'(bus.busy_o), 128'd0);
      tick();
    end
    run_vec(0);

    // Perf counters: scenario with one retry, twice, from a clean reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(1);
    run_vec(1);
`ifdef DISPATCH_PERF_CTR_EN
    exp_pb = 32'd2;
    exp_pr = 32'd4;
`else
    exp_pb = 32'd0;
    exp_pr = 32'd0;
`endif
    chk("perf_batches", 128'(bus.perf_batches_o), 128'(exp_pb));
    chk("perf_retry_cycles", 128'(bus.perf_retry_cycles_o), 128'(exp_pr));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
